// File: rtl/fetch_pkg.sv
// Shared defaults and the queue entry record for the instruction fetch memory.
package fetch_pkg;

  localparam int FETCH_DATA_W = 16;
  localparam int FETCH_ADDR_W = 9;

  localparam logic [FETCH_DATA_W-1:0] NOP_WORD = '0;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0] pc;
    logic [FETCH_DATA_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/instr_queue.sv
// Small synchronous FIFO with flush; head is read straight from registered storage.
module instr_queue #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [DEPTH-1:0][WIDTH-1:0] store;
  logic [PW-1:0]               rd_ptr;
  logic [PW-1:0]               wr_ptr;
  logic                        do_push;
  logic                        do_pop;

  assign do_pop  = pop && (count != '0);
  // A push into a full queue is only taken when the head leaves the same cycle.
  assign do_push = push && ((count < CW'(DEPTH)) || do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      store  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= wr_ptr + PW'(1);
      end
      if (do_pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head  = store[rd_ptr];
  assign valid = (count != '0);

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction RAM with autonomous sequential prefetch into a valid/ready stream.
module instr_fetch_mem
  import fetch_pkg::*;
#(
  parameter int DATA_W      = FETCH_DATA_W,
  parameter int ADDR_W      = FETCH_ADDR_W,
  parameter int QUEUE_DEPTH = 4,
  parameter     INIT_FILE   = ""
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] fetch_pc
);

  localparam int MEM_DEPTH = 1 << ADDR_W;
  localparam int CW        = $clog2(QUEUE_DEPTH) + 1;
  localparam int EW        = ADDR_W + DATA_W;

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_pc;
  logic              inflight;
  logic [CW-1:0]     count;
  logic [CW:0]       occupancy;
  logic              pop;
  logic              issue;
  logic              push;
  logic [EW-1:0]     head;

  assign pop = instr_valid && instr_ready;

  // Slots already claimed after this edge; pop implies count >= 1, so no underflow.
  assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);

  assign issue = enable && !redirect_valid && !prog_we &&
                 (occupancy < (CW+1)'(QUEUE_DEPTH));

  // Single shared port: a programming write steals the read slot.
  always_ff @(posedge clock) begin
    if (prog_we)
      mem[prog_addr] <= prog_data;
    if (issue) begin
      rd_data <= mem[fetch_pc];
      rd_pc   <= fetch_pc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (redirect_valid)
        fetch_pc <= redirect_pc;
      else if (issue)
        fetch_pc <= fetch_pc + ADDR_W'(1);
    end
  end

  // An in-flight word landing on a redirect edge belongs to the old stream.
  assign push = inflight && !redirect_valid;

  instr_queue #(
    .WIDTH (EW),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({rd_pc, rd_data}),
    .pop       (pop),
    .head      (head),
    .valid     (instr_valid),
    .count     (count)
  );

  assign instr_pc   = head[EW-1:DATA_W];
  assign instr_data = head[DATA_W-1:0];

endmodule
